// File: rtl/mem_arbiter_2p_pkg.sv
// Shared definitions for the two-port memory arbiter: bus widths of the
// MEMORY_64MB system, FSM state encoding and requester port indices.
package mem_arbiter_2p_pkg;

   // Memory word width and word address width (64M words)
   localparam int MEM_DATA_WIDTH    = 32;
   localparam int MEM_ADDRESS_WIDTH = 26;

   // Longest access the 4-bit cycle counter can sequence
   localparam int MAX_ACCESS_CYCLES = 15;

   // Requester port indices
   localparam logic PORT_IFETCH = 1'b0;
   localparam logic PORT_LDST   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   // Counter preload for an access of the given length, clamped to 1..15
   function automatic logic [3:0] access_count_init(input int cycles);
      int c;
      c = cycles;
      if (c < 1) c = 1;
      if (c > MAX_ACCESS_CYCLES) c = MAX_ACCESS_CYCLES;
      return 4'(c - 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_2p_if.sv
// Requester-side handshake bundle for the two arbiter ports
// (port 0 = instruction fetch, port 1 = load/store).
// master: the processor side; slave: the arbiter.
interface mem_arbiter_2p_if
   import mem_arbiter_2p_pkg::*;
#(
   parameter int DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDRESS_WIDTH
);
   logic                  REQ0;
   logic                  REQ1;
   logic                  WE0;
   logic                  WE1;
   logic [ADDR_WIDTH-1:0] ADDR0;
   logic [ADDR_WIDTH-1:0] ADDR1;
   logic [DATA_WIDTH-1:0] WDATA0;
   logic [DATA_WIDTH-1:0] WDATA1;
   logic                  ACK0;
   logic                  ACK1;
   logic [DATA_WIDTH-1:0] RDATA0;
   logic [DATA_WIDTH-1:0] RDATA1;

   modport master (
      output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
      input  ACK0, ACK1, RDATA0, RDATA1
   );

   modport slave (
      input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1,
      output ACK0, ACK1, RDATA0, RDATA1
   );
endinterface

// File: rtl/mem_arbiter_2p_select.sv
// mem_arb_select: combinational winner selection between the two ports.
// MEM_ARB_RR_EN defined  : round-robin on ties (port not served last wins).
// MEM_ARB_RR_EN undefined: fixed priority, the load/store port wins ties.
module mem_arb_select
   import mem_arbiter_2p_pkg::*;
(
   input  logic req0,
   input  logic req1,
`ifdef MEM_ARB_RR_EN
   input  logic last_grant,
`endif
   output logic any_req,
   output logic winner
);

   // Pick the port to serve from the current requests
   always_comb begin
      any_req = req0 | req1;
      winner  = PORT_IFETCH;
`ifdef MEM_ARB_RR_EN
      if (req0 && req1) begin
         winner = (last_grant == PORT_IFETCH) ? PORT_LDST : PORT_IFETCH;
      end else if (req1) begin
         winner = PORT_LDST;
      end
`else
      if (req1) begin
         winner = PORT_LDST;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: two-port arbiter and access sequencer for the shared
// memory bus. Serves one requester at a time through IDLE -> ACCESS (held
// for ACCESS_CYCLES cycles) -> RESP, with a one-cycle ACK in RESP.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking);
// without it port 1 has fixed priority and no pointer register exists.
module mem_arbiter_2p
   import mem_arbiter_2p_pkg::*;
#(
   parameter int DATA_WIDTH    = MEM_DATA_WIDTH,
   parameter int ADDR_WIDTH    = MEM_ADDRESS_WIDTH,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   mem_arbiter_2p_if.slave       req,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   inout  wire  [DATA_WIDTH-1:0] MEM_DATA,
   output logic                  BUSY,
   output logic                  GRANT
);

   localparam logic [3:0] CNT_INIT = access_count_init(ACCESS_CYCLES);

   arb_state_t            state;
   arb_state_t            state_nx;
   logic [3:0]            cnt;
   logic                  grant;
   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  any_req;
   logic                  winner;
   logic                  load_req;
   logic                  capture_rd;
   logic                  mem_data_oe;

`ifdef MEM_ARB_RR_EN
   logic                  last_grant;

   mem_arb_select u_select (
      .req0       (req.REQ0),
      .req1       (req.REQ1),
      .last_grant (last_grant),
      .any_req    (any_req),
      .winner     (winner)
   );

   // Round-robin pointer: remembers the port served by the latest grant
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last_grant <= PORT_LDST;
      end else if (load_req) begin
         last_grant <= winner;
      end
   end
`else
   mem_arb_select u_select (
      .req0    (req.REQ0),
      .req1    (req.REQ1),
      .any_req (any_req),
      .winner  (winner)
   );
`endif

   // FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic and bus/handshake outputs decoded from the state
   always_comb begin
      state_nx    = state;
      load_req    = 1'b0;
      capture_rd  = 1'b0;
      BUSY        = 1'b1;
      MEM_READ    = 1'b0;
      MEM_WRITE   = 1'b0;
      mem_data_oe = 1'b0;
      req.ACK0    = 1'b0;
      req.ACK1    = 1'b0;
      case (state)
         ST_IDLE: begin
            BUSY = 1'b0;
            if (any_req) begin
               load_req = 1'b1;
               state_nx = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            MEM_READ    = ~lat_we;
            MEM_WRITE   = lat_we;
            mem_data_oe = lat_we;
            if (cnt == 4'd0) begin
               capture_rd = ~lat_we;
               state_nx   = ST_RESP;
            end
         end
         ST_RESP: begin
            req.ACK0 = (grant == PORT_IFETCH);
            req.ACK1 = (grant == PORT_LDST);
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Grant, request latch and access cycle counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         grant    <= PORT_IFETCH;
         lat_we   <= 1'b0;
         lat_addr <= '0;
         cnt      <= 4'd0;
      end else if (load_req) begin
         grant    <= winner;
         lat_we   <= (winner == PORT_LDST) ? req.WE1   : req.WE0;
         lat_addr <= (winner == PORT_LDST) ? req.ADDR1 : req.ADDR0;
         cnt      <= CNT_INIT;
      end else if (state == ST_ACCESS && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Write data latch; only ever driven onto the bus after a fresh load
   always_ff @(posedge CLK) begin
      if (load_req) begin
         lat_wdata <= (winner == PORT_LDST) ? req.WDATA1 : req.WDATA0;
      end
   end

   // Per-port read data, updated only when a read on that port completes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (capture_rd) begin
         if (grant == PORT_LDST) begin
            rdata1 <= MEM_DATA;
         end else begin
            rdata0 <= MEM_DATA;
         end
      end
   end

   assign MEM_DATA   = mem_data_oe ? lat_wdata : {DATA_WIDTH{1'bz}};
   assign MEM_ADDR   = lat_addr;
   assign GRANT      = grant;
   assign req.RDATA0 = rdata0;
   assign req.RDATA1 = rdata1;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a small memory model on the bus.
// Expected values are hand-computed for ACCESS_CYCLES = 1.
module tb_mem_arbiter_2p;
   import mem_arbiter_2p_pkg::*;

   localparam int DW = 32;
   localparam int AW = 26;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   wire  [DW-1:0] MEM_DATA;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_READ;
   logic          MEM_WRITE;
   logic          BUSY;
   logic          GRANT;

   int n_cmp = 0;
   int n_mis = 0;
   int viol  = 0;

   mem_arbiter_2p_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq ();

   mem_arbiter_2p #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .ACCESS_CYCLES (1)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req       (rq),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_READ  (MEM_READ),
      .MEM_WRITE (MEM_WRITE),
      .MEM_DATA  (MEM_DATA),
      .BUSY      (BUSY),
      .GRANT     (GRANT)
   );

   always #5 CLK = ~CLK;

   // Memory model: 8K words, preloaded with mem_content_01 at 0x1000..0x1003
   logic [DW-1:0] mem [0:8191];
   logic          mem_loaded = 1'b0;
   wire  [12:0]   mem_idx = MEM_ADDR[12:0];
   wire           mem_hit = (MEM_ADDR[AW-1:13] == '0);

   assign MEM_DATA = MEM_READ ? (mem_hit ? mem[mem_idx] : 32'hDEAD_BEEF) : {DW{1'bz}};

   always @(posedge CLK) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 8192; i++) begin
            mem[i] <= (i >= 4096 && i < 4100) ? 32'h0041_4020 + 32'(i - 4096) : 32'h0;
         end
         mem_loaded <= 1'b1;
      end else if (MEM_WRITE && mem_hit) begin
         mem[mem_idx] <= MEM_DATA;
      end
   end

   // Bus contention monitor
   always @(negedge CLK) begin
      if (RST) begin
         if (MEM_READ && dut.mem_data_oe) viol++;
         if (MEM_READ && MEM_WRITE)       viol++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete access on a port; REQ dropped as soon as ACK is seen
   task automatic access(input logic port, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input string tag,
                         output logic [DW-1:0] rd);
      int  n;
      logic got;
      @(posedge CLK);
      #1;
      if (port) begin
         rq.WE1 = we; rq.ADDR1 = a; rq.WDATA1 = d; rq.REQ1 = 1'b1;
      end else begin
         rq.WE0 = we; rq.ADDR0 = a; rq.WDATA0 = d; rq.REQ0 = 1'b1;
      end
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge CLK);
         n++;
         if (n == 2) begin
            chk({tag, "_rd"},    64'(MEM_READ),  64'(!we));
            chk({tag, "_wr"},    64'(MEM_WRITE), 64'(we));
            chk({tag, "_addr"},  64'(MEM_ADDR),  64'(a));
            chk({tag, "_grant"}, 64'(GRANT),     64'(port));
            if (we) chk({tag, "_wdata"}, 64'(MEM_DATA), 64'(d));
         end
         got = port ? rq.ACK1 : rq.ACK0;
      end
      chk({tag, "_lat"}, 64'(n), 64'd3);
      rd = port ? rq.RDATA1 : rq.RDATA0;
      rq.REQ0 = 1'b0;
      rq.REQ1 = 1'b0;
      @(negedge CLK);
      chk({tag, "_ackpulse"}, 64'(port ? rq.ACK1 : rq.ACK0), 64'd0);
      chk({tag, "_idle"},     64'(BUSY), 64'd0);
   endtask

   initial begin
      int            k;
      int            n;
      int            last;
      int            a0;
      int            exp_a0;
      logic          got;
      logic [3:0]    exp_seq;
      logic [DW-1:0] rd;

      rq.REQ0 = 1'b0; rq.REQ1 = 1'b0; rq.WE0 = 1'b0; rq.WE1 = 1'b0;
      rq.ADDR0 = '0;  rq.ADDR1 = '0;  rq.WDATA0 = '0; rq.WDATA1 = '0;

      // Reset held with a pending request
      #2 RST = 1'b0;
      rq.REQ0 = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("rst_ack0",  64'(rq.ACK0),       64'd0);
         chk("rst_ack1",  64'(rq.ACK1),       64'd0);
         chk("rst_rd",    64'(MEM_READ),      64'd0);
         chk("rst_wr",    64'(MEM_WRITE),     64'd0);
         chk("rst_drive", 64'(dut.mem_data_oe), 64'd0);
         chk("rst_busy",  64'(BUSY),          64'd0);
         chk("rst_grant", 64'(GRANT),         64'd0);
         chk("rst_addr",  64'(MEM_ADDR),      64'd0);
         chk("rst_rdata0", 64'(rq.RDATA0),    64'd0);
      end
      rq.REQ0 = 1'b0;
      @(negedge CLK);
      #2 RST = 1'b1;

      // Port 1 write, then port 0 reads it back
      access(1'b1, 1'b1, 26'h000_0005, 32'h0000_0005, "wr1", rd);
      chk("wr1_mem",    64'(mem[5]),     64'h5);
      chk("wr1_rdata1", 64'(rq.RDATA1),  64'h0);
      access(1'b0, 1'b0, 26'h000_0005, 32'h0, "rd0", rd);
      chk("rd0_data",   64'(rd),         64'h5);

      // Back-to-back reads of mem_content_01 with REQ0 held
      @(posedge CLK);
      #1;
      rq.WE0 = 1'b0; rq.ADDR0 = 26'h000_1000; rq.REQ0 = 1'b1;
      k = 0; n = 0; last = 0;
      while (k < 4 && n < 40) begin
         @(negedge CLK);
         n++;
         if (rq.ACK0) begin
            chk("b2b_data", 64'(rq.RDATA0), 64'(32'h0041_4020 + 32'(k)));
            if (k > 0) chk("b2b_gap", 64'(n - last), 64'd3);
            last = n;
            k++;
            if (k < 4) rq.ADDR0 = 26'h000_1000 + 26'(k);
            else       rq.REQ0 = 1'b0;
         end
      end
      chk("b2b_count", 64'(k), 64'd4);

      // Fresh reset so the round-robin pointer is back at its initial value
      @(negedge CLK);
      #2 RST = 1'b0;
      #2 RST = 1'b1;

      // Simultaneous continuous requests
`ifdef MEM_ARB_RR_EN
      exp_seq = 4'b1010;
      exp_a0  = 2;
`else
      exp_seq = 4'b1111;
      exp_a0  = 0;
`endif
      @(posedge CLK);
      #1;
      rq.WE0 = 1'b0; rq.WE1 = 1'b0;
      rq.ADDR0 = 26'h000_1000; rq.ADDR1 = 26'h000_1001;
      rq.REQ0 = 1'b1; rq.REQ1 = 1'b1;
      k = 0; n = 0; a0 = 0;
      while (k < 4 && n < 60) begin
         @(negedge CLK);
         n++;
         if (rq.ACK0 || rq.ACK1) begin
            chk("tie_grant", 64'(GRANT), 64'(exp_seq[k]));
            if (rq.ACK0) begin
               a0++;
               chk("tie_rd0", 64'(rq.RDATA0), 64'h0041_4020);
            end
            if (rq.ACK1) chk("tie_rd1", 64'(rq.RDATA1), 64'h0041_4021);
            k++;
            if (k == 4) begin
               rq.REQ0 = 1'b0;
               rq.REQ1 = 1'b0;
            end
         end
      end
      chk("tie_count", 64'(k),  64'd4);
      chk("tie_ack0",  64'(a0), 64'(exp_a0));
      @(negedge CLK);
      @(negedge CLK);

      // Reset asserted during the ACCESS cycle of a read
      @(posedge CLK);
      #1;
      rq.WE0 = 1'b0; rq.ADDR0 = 26'h000_1002; rq.REQ0 = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("mid_pre_busy", 64'(BUSY),     64'd1);
      chk("mid_pre_rd",   64'(MEM_READ), 64'd1);
      #1 RST = 1'b0;
      #1;
      chk("mid_busy",  64'(BUSY),      64'd0);
      chk("mid_rd",    64'(MEM_READ),  64'd0);
      chk("mid_state", 64'(dut.state), 64'(ST_IDLE));
      repeat (2) begin
         @(negedge CLK);
         chk("mid_ack0", 64'(rq.ACK0), 64'd0);
         chk("mid_rd_held", 64'(MEM_READ), 64'd0);
      end
      #2 RST = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge CLK);
         n++;
         got = rq.ACK0;
      end
      chk("mid_reissue_ack",  64'(got), 64'd1);
      chk("mid_reissue_lat",  64'(n),   64'd2);
      chk("mid_reissue_data", 64'(rq.RDATA0), 64'h0041_4022);
      rq.REQ0 = 1'b0;
      @(negedge CLK);
      chk("mid_ackpulse", 64'(rq.ACK0), 64'd0);

      chk("contention", 64'(viol), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Absolute time bound on the whole run
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
